// File: rtl/instr_issuer.sv
// Instruction issuer: packs decoded fields into 8-bit control words, queues them, and strobes them
// out one at a time with a programmable idle gap. Define ISSUER_ILLEGAL_TRAP_EN to drop op 111 onto err.

module issuer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level <= level + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level <= level - 1'b1;
      end
    end
  end
endmodule

module instr_issuer #(
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic                   ra1,
  input  logic                   ra2,
  input  logic                   wa,
  input  logic [3:0]             wd,
  input  logic                   stall,
  output logic [7:0]             instruction,
  output logic                   load,
  output logic                   busy,
`ifdef ISSUER_ILLEGAL_TRAP_EN
  output logic                   err,
`endif
  output logic [$clog2(DEPTH):0] level
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

  typedef struct packed {
    logic [2:0] op;
    logic       ra1;
    logic       ra2;
    logic       wa;
    logic [3:0] wd;
  } fields_t;

  function automatic logic [7:0] encode(input fields_t f);
    case (f.op)
      3'b000:                 return {6'b000000, f.ra2, f.ra1};
      3'b001, 3'b010, 3'b011: return {f.op, f.ra1, 4'b0000};
      3'b100, 3'b101:         return {f.op, f.ra1, f.ra2, 3'b000};
      3'b110:                 return {f.op, f.wa, f.wd};
      default:                return {3'b111, 5'b00000};
    endcase
  endfunction

  fields_t       in_fields;
  logic          accept;
  logic          push;
  logic          pop;
  logic [7:0]    head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    state;
  logic [GW-1:0] gap_cnt;

  assign in_fields = '{op: op, ra1: ra1, ra2: ra2, wa: wa, wd: wd};
  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;

`ifdef ISSUER_ILLEGAL_TRAP_EN
  logic is_illegal;
  assign is_illegal = (op == 3'b111);
  // Illegal words complete the handshake so the producer is never wedged, but never reach the queue.
  assign push = accept && !is_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && is_illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign push = accept;
`endif

  assign pop  = (state == S_IDLE) && !fifo_empty && !stall;
  assign busy = !fifo_empty || (state != S_IDLE);

  issuer_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_dat(encode(in_fields)),
    .pop     (pop),
    .head_dat(head_dat),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ISSUE always returns through IDLE, so loads are at least two cycles apart even with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instruction <= 8'h00;
      load        <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            instruction <= head_dat;
            load        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ISSUE_GAP == 0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= GAP_INIT;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: one gap-1 instance and one gap-0 instance, hand-computed words.
module tb_instr_issuer;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, stall, g_valid, g_stall;
  logic [2:0]    op;
  logic          ra1, ra2, wa;
  logic [3:0]    wd;
  logic          in_ready, load, busy;
  logic [7:0]    instruction;
  logic [LW-1:0] level;
  logic          g_ready, g_load, g_busy;
  logic [7:0]    g_instr;
  logic [LW-1:0] g_level;
`ifdef ISSUER_ILLEGAL_TRAP_EN
  logic          err, g_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0] enc_op  [4] = '{3'b000, 3'b011, 3'b100, 3'b101};
  logic       enc_ra1 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic       enc_ra2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] enc_exp [4] = '{8'h01, 8'h70, 8'h98, 8'hA8};
  logic [7:0] g_exp   [3] = '{8'h30, 8'h40, 8'hC7};

  always #5 clk = ~clk;

  instr_issuer #(.DEPTH(DEPTH), .ISSUE_GAP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd), .stall(stall),
    .instruction(instruction), .load(load), .busy(busy),
`ifdef ISSUER_ILLEGAL_TRAP_EN
    .err(err),
`endif
    .level(level)
  );

  instr_issuer #(.DEPTH(DEPTH), .ISSUE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(g_valid), .in_ready(g_ready),
    .op(op), .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd), .stall(g_stall),
    .instruction(g_instr), .load(g_load), .busy(g_busy),
`ifdef ISSUER_ILLEGAL_TRAP_EN
    .err(g_err),
`endif
    .level(g_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] o, input logic a1, input logic a2,
                            input logic w, input logic [3:0] d);
    op = o; ra1 = a1; ra2 = a2; wa = w; wd = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; g_valid = 1'b0; g_stall = 1'b0;
    set_fields(3'b000, 1'b0, 1'b0, 1'b0, 4'h0);
    tick(); tick();
    rst = 1'b0;
    total++; if (instruction !== 8'h00) begin bad++; $display("FAIL reset_instr got=%h want=00", instruction); end
    total++; if (load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b want=0", load); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick();
  endtask

  task automatic test_single();
    set_fields(3'b110, 1'b0, 1'b0, 1'b1, 4'hA);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (load !== 1'b0) begin bad++; $display("FAIL single_n1_load got=%b want=0", load); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL single_n1_level got=%0d want=1", level); end
    tick();
    total++; if (load !== 1'b1) begin bad++; $display("FAIL single_n2_load got=%b want=1", load); end
    total++; if (instruction !== 8'hDA) begin bad++; $display("FAIL single_n2_instr got=%h want=DA", instruction); end
    tick();
    total++; if (load !== 1'b0) begin bad++; $display("FAIL single_n3_load got=%b want=0", load); end
    total++; if (instruction !== 8'hDA) begin bad++; $display("FAIL single_hold_instr got=%h want=DA", instruction); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap_busy got=%b want=1", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_encodings();
    int n = 0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(enc_op[i], enc_ra1[i], enc_ra2[i], 1'b1, 4'hF);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    total++; if (level !== 3'd4) begin bad++; $display("FAIL enc_level got=%0d want=4", level); end
    stall = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (load === 1'b1) begin
        total++;
        if (n >= 4 || instruction !== enc_exp[n & 3]) begin
          bad++; $display("FAIL enc_word%0d got=%h want=%h", n, instruction, enc_exp[n & 3]);
        end
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL enc_count got=%0d want=4", n); end
  endtask

  task automatic test_full_stall();
    int n = 0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(3'b110, 1'b0, 1'b0, 1'b0, 4'(i + 1));
      in_valid = 1'b1;
      tick();
    end
    set_fields(3'b110, 1'b0, 1'b0, 1'b0, 4'h5);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d want=4", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    tick();
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_held_level got=%0d want=4", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_held_ready got=%b want=0", in_ready); end
    stall = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1) begin
        total++; if (level !== 3'd3) begin bad++; $display("FAIL full_pop_level got=%0d want=3", level); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%b want=1", in_ready); end
      end
      if (c == 2) begin
        in_valid = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_fifth_level got=%0d want=4", level); end
      end
      if (load === 1'b1) begin
        total++;
        if (instruction !== 8'(8'hC1 + n)) begin
          bad++; $display("FAIL full_word%0d got=%h want=%h", n, instruction, 8'(8'hC1 + n));
        end
        total++;
        if (c != 1 + 3 * n) begin bad++; $display("FAIL full_cycle%0d got=%0d want=%0d", n, c, 1 + 3 * n); end
        n++;
      end
    end
    total++; if (n != 5) begin bad++; $display("FAIL full_count got=%0d want=5", n); end
  endtask

  task automatic test_gap0();
    int n = 0;
    g_stall = 1'b1;
    set_fields(3'b001, 1'b1, 1'b0, 1'b0, 4'h0); g_valid = 1'b1; tick();
    set_fields(3'b010, 1'b0, 1'b1, 1'b0, 4'h0); tick();
    set_fields(3'b110, 1'b0, 1'b0, 1'b0, 4'h7); tick();
    g_valid = 1'b0;
    total++; if (g_level !== 3'd3) begin bad++; $display("FAIL gap0_level got=%0d want=3", g_level); end
    g_stall = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (g_load === 1'b1) begin
        total++;
        if (n >= 3 || g_instr !== g_exp[n % 3]) begin
          bad++; $display("FAIL gap0_word%0d got=%h want=%h", n, g_instr, g_exp[n % 3]);
        end
        total++;
        if (c != 1 + 2 * n) begin bad++; $display("FAIL gap0_cycle%0d got=%0d want=%0d", n, c, 1 + 2 * n); end
        n++;
      end else if (c == 2) begin
        total++; if (g_instr !== 8'h30) begin bad++; $display("FAIL gap0_hold got=%h want=30", g_instr); end
      end
    end
    total++; if (n != 3) begin bad++; $display("FAIL gap0_count got=%0d want=3", n); end
  endtask

  task automatic test_illegal();
    set_fields(3'b111, 1'b1, 1'b1, 1'b1, 4'hF);
    in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
`ifdef ISSUER_ILLEGAL_TRAP_EN
    total++; if (level !== 3'd0) begin bad++; $display("FAIL illegal_level got=%0d want=0", level); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (load !== 1'b0) begin bad++; $display("FAIL illegal_load%0d got=%b want=0", c, load); end
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b want=1", err); end
`else
    total++; if (level !== 3'd1) begin bad++; $display("FAIL illegal_level got=%0d want=1", level); end
    tick();
    total++; if (load !== 1'b1) begin bad++; $display("FAIL illegal_load got=%b want=1", load); end
    total++; if (instruction !== 8'hE0) begin bad++; $display("FAIL illegal_word got=%h want=E0", instruction); end
    tick(); tick();
`endif
  endtask

  task automatic test_reset_mid();
    int loads = 0;
    stall = 1'b1;
    set_fields(3'b110, 1'b0, 1'b0, 1'b0, 4'h9);
    in_valid = 1'b1; tick(); tick();
    in_valid = 1'b0;
    stall = 1'b0;
    tick();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    total++; if (instruction !== 8'h00) begin bad++; $display("FAIL rmid_instr got=%h want=00", instruction); end
    total++; if (load !== 1'b0) begin bad++; $display("FAIL rmid_load got=%b want=0", load); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rmid_level got=%0d want=0", level); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
`ifdef ISSUER_ILLEGAL_TRAP_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b want=0", err); end
`endif
    for (int c = 0; c < 5; c++) begin
      tick();
      if (load === 1'b1) loads++;
    end
    total++; if (loads != 0) begin bad++; $display("FAIL rmid_stale_loads got=%0d want=0", loads); end
    set_fields(3'b000, 1'b0, 1'b1, 1'b0, 4'h0);
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    total++; if (load !== 1'b1) begin bad++; $display("FAIL rmid_after_load got=%b want=1", load); end
    total++; if (instruction !== 8'h02) begin bad++; $display("FAIL rmid_after_word got=%h want=02", instruction); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_encodings();
    test_full_stall();
    test_gap0();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
